// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and enums for the 8-bit CPU control path
//
// Purpose : opcode, ALU operation and sequencer state encodings, plus fixed widths.
// Ports   : none (package).
// Config  : CPU_CTRL_BRANCH_EN is consumed by cpu_op_decode and cpu_ctrl_seq.

package cpu_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_ADDI = 4'h6,
    OP_LDI  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BZ   = 4'h9,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSA = 3'd5,
    ALU_PASSB = 3'd6
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/cpu_op_decode.sv
// rtl/cpu_op_decode.sv - combinational instruction decoder
//
// Purpose : maps the instruction register onto register file addresses, ALU
//           operation, immediate operand and a register-write flag.
// Ports   : ir         in  16  instruction register
//           ra1/ra2/wa out 4   read address 1/2, write address
//           alu_op     out 3   ALU operation (alu_op_t encoding)
//           imm        out 8   immediate operand
//           use_imm    out 1   ALU B operand taken from imm
//           writes_reg out 1   instruction writes the register file
// Config  : CPU_CTRL_BRANCH_EN enables the BZ operand override.

module cpu_op_decode
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ra1,
  output logic [ADDR_W-1:0]  ra2,
  output logic [ADDR_W-1:0]  wa,
  output logic [2:0]         alu_op,
  output logic [DATA_W-1:0]  imm,
  output logic               use_imm,
  output logic               writes_reg
);

  always_comb begin
    ra1        = ir[7:4];
    ra2        = ir[3:0];
    wa         = ir[11:8];
    alu_op     = ALU_ADD;
    imm        = '0;
    use_imm    = 1'b0;
    writes_reg = 1'b0;
    case (opcode_t'(ir[15:12]))
      OP_ADD: writes_reg = 1'b1;
      OP_SUB: begin alu_op = ALU_SUB; writes_reg = 1'b1; end
      OP_AND: begin alu_op = ALU_AND; writes_reg = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;  writes_reg = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR; writes_reg = 1'b1; end
      OP_ADDI: begin
        imm        = {4'b0000, ir[3:0]};
        use_imm    = 1'b1;
        writes_reg = 1'b1;
      end
      OP_LDI: begin
        alu_op     = ALU_PASSB;
        imm        = ir[7:0];
        use_imm    = 1'b1;
        writes_reg = 1'b1;
      end
`ifdef CPU_CTRL_BRANCH_EN
      // BZ tests rd: route it through port A so the ALU zero flag reflects it.
      OP_BZ: begin
        ra1    = ir[11:8];
        alu_op = ALU_PASSA;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - multi-cycle fetch/decode/execute sequencer
//
// Purpose : three cycles per instruction (FETCH, DECODE, EXECUTE); holds the
//           FSM, instruction register and pc; drives register file / ALU controls.
// Ports   : clk          in  1   clock, rising edge
//           RESET        in  1   asynchronous active-high reset
//           run          in  1   start/continue execution
//           instr        in  16  instruction word at pc (combinational read)
//           zero         in  1   ALU result is zero, sampled in EXECUTE
//           pc           out 8   instruction address
//           RA1/RA2/WA   out 4   register file read/write addresses
//           write_enable out 1   register file write strobe
//           alu_op       out 3   ALU operation
//           imm          out 8   immediate operand
//           use_imm      out 1   ALU B operand = imm
//           halted       out 1   HALT executed
// Config  : CPU_CTRL_BRANCH_EN defined -> JMP/BZ implemented; undefined -> they
//           act as NOP, pc always increments and zero is ignored.

module cpu_ctrl_seq
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               RESET,
  input  logic               run,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic [ADDR_W-1:0]  RA1,
  output logic [ADDR_W-1:0]  RA2,
  output logic [ADDR_W-1:0]  WA,
  output logic               write_enable,
  output logic [2:0]         alu_op,
  output logic [DATA_W-1:0]  imm,
  output logic               use_imm,
  output logic               halted
);

  ctrl_state_t        state;
  logic [INSTR_W-1:0] ir;
  logic               writes_reg;
  logic [PC_W-1:0]    next_pc;
  opcode_t            op;

  assign op = opcode_t'(ir[15:12]);

  cpu_op_decode u_decode (
    .ir         (ir),
    .ra1        (RA1),
    .ra2        (RA2),
    .wa         (WA),
    .alu_op     (alu_op),
    .imm        (imm),
    .use_imm    (use_imm),
    .writes_reg (writes_reg)
  );

  // Derived from the registered state only, so it cannot glitch and drops
  // the moment reset forces state back to IDLE.
  assign write_enable = (state == ST_EXECUTE) && writes_reg;

`ifdef CPU_CTRL_BRANCH_EN
  always_comb begin
    next_pc = pc + 8'd1;
    if (op == OP_JMP || (op == OP_BZ && zero))
      next_pc = ir[7:0];
  end
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign next_pc     = pc + 8'd1;
`endif

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:   if (run) state <= ST_FETCH;
        ST_FETCH: begin
          ir    <= instr;
          state <= ST_DECODE;
        end
        ST_DECODE: state <= ST_EXECUTE;
        ST_EXECUTE: begin
          if (op == OP_HALT) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            pc    <= next_pc;
            state <= run ? ST_FETCH : ST_IDLE;
          end
        end
        ST_HALT:   state <= ST_HALT;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - directed self-checking bench for cpu_ctrl_seq

module tb_cpu_ctrl_seq;
  import cpu_pkg::*;

`ifdef CPU_CTRL_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        run = 1'b0;
  logic        zero = 1'b0;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic [7:0]  imm;
  logic        use_imm;
  logic        halted;

  logic [15:0] mem [256];
  int          total = 0;
  int          bad = 0;

  assign instr = mem[pc];

  always #5 clk = ~clk;

  cpu_ctrl_seq dut (
    .clk          (clk),
    .RESET        (RESET),
    .run          (run),
    .instr        (instr),
    .zero         (zero),
    .pc           (pc),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .imm          (imm),
    .use_imm      (use_imm),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Reset, then release with run=1; returns at the negedge inside the first FETCH.
  task automatic start();
    RESET = 1'b1;
    run   = 1'b0;
    @(negedge clk);
    RESET = 1'b0;
    run   = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int we_cnt;
    bit found;

    // ---- reset state, ADDI, LDI, BZ taken ----
    clear_mem();
    mem[0] = 16'h6304;
    mem[1] = 16'h7505;
    mem[2] = 16'h9240;
    @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("rst_pc", 32'(pc), 0);
    check("rst_addr", {20'b0, RA1, RA2, WA}, 0);
    check("rst_we", 32'(write_enable), 0);
    check("rst_alu", 32'(alu_op), 0);
    check("rst_imm", {23'b0, use_imm, imm}, 0);
    check("rst_halted", 32'(halted), 0);

    start();
    check("addi_fetch", 32'(dut.state), 32'(ST_FETCH));
    step(1);
    check("addi_decode", 32'(dut.state), 32'(ST_DECODE));
    check("addi_dec_we", 32'(write_enable), 0);
    step(1);
    check("addi_exec", 32'(dut.state), 32'(ST_EXECUTE));
    check("addi_we", 32'(write_enable), 1);
    check("addi_wa_ra1", {RA1, WA}, 32'h03);
    check("addi_imm", {23'b0, use_imm, imm}, 32'h104);
    check("addi_alu", 32'(alu_op), 32'(ALU_ADD));
    step(1);
    check("addi_we_end", 32'(write_enable), 0);
    check("addi_pc", 32'(pc), 1);
    step(2);
    check("ldi_we", 32'(write_enable), 1);
    check("ldi_wa", 32'(WA), 5);
    check("ldi_imm", {23'b0, use_imm, imm}, 32'h105);
    check("ldi_alu", 32'(alu_op), 32'(ALU_PASSB));
    step(1);
    check("ldi_pc", 32'(pc), 2);
    zero = 1'b1;
    step(2);
    check("bz_ra1", 32'(RA1), BR ? 2 : 4);
    check("bz_alu", 32'(alu_op), BR ? 32'(ALU_PASSA) : 32'(ALU_ADD));
    check("bz_we", 32'(write_enable), 0);
    step(1);
    check("bz_taken_pc", 32'(pc), BR ? 32'h40 : 3);

    // ---- BZ not taken ----
    zero = 1'b0;
    start();
    step(9);
    check("bz_nt_pc", 32'(pc), 3);

    // ---- JMP ----
    mem[1] = 16'h8010;
    start();
    step(3);
    we_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (write_enable) we_cnt++;
    end
    check("jmp_we_cnt", we_cnt, 0);
    check("jmp_pc", 32'(pc), BR ? 32'h10 : 2);

    // ---- pc wrap and HALT ----
    clear_mem();
    start();
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (pc == 8'hFF && dut.state == ST_FETCH) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_pc_ff", 32'(found), 1);
    step(3);
    check("wrap_pc", 32'(pc), 0);
    check("wrap_state", 32'(dut.state), 32'(ST_FETCH));
    mem[0] = 16'hF000;
    step(2);
    check("halt_exec_halted", 32'(halted), 0);
    step(1);
    check("halt_state", 32'(dut.state), 32'(ST_HALT));
    check("halt_halted", 32'(halted), 1);
    we_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (write_enable) we_cnt++;
    end
    check("halt_we_cnt", we_cnt, 0);
    check("halt_pc", 32'(pc), 0);
    check("halt_hold", {31'b0, halted}, 1);

    // ---- run dropped during DECODE of ADD ----
    clear_mem();
    mem[0] = 16'h1123;
    start();
    step(1);
    run = 1'b0;
    step(1);
    check("drop_we", 32'(write_enable), 1);
    check("drop_wa", 32'(WA), 1);
    step(1);
    check("drop_state", 32'(dut.state), 32'(ST_IDLE));
    check("drop_pc", 32'(pc), 1);
    step(2);
    check("drop_idle_hold", {24'b0, dut.state, pc[4:0]}, {24'b0, ST_IDLE, 5'd1});

    // ---- RESET during EXECUTE ----
    clear_mem();
    mem[0] = 16'h6304;
    mem[1] = 16'h7505;
    start();
    step(5);
    check("rx_pre_we", 32'(write_enable), 1);
    check("rx_pre_pc", 32'(pc), 1);
    #1 RESET = 1'b1;
    #1;
    check("rx_we", 32'(write_enable), 0);
    check("rx_pc", 32'(pc), 0);
    check("rx_state", 32'(dut.state), 32'(ST_IDLE));
    RESET = 1'b0;
    run = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
